output_controller: RTL and testbench
====================================

OUTPUT_CONTROLLER -- requirements
Module: output_controller

Interface
REQ-001 SHALL have parameter DEPTH, default 1024, meaning the FIFO capacity in 32-bit words (power of two, at least 2).
REQ-002 SHALL have parameter NBYTES, default 1, meaning the bytes sent per word, LSB first (legal values 1 or 4).
REQ-003 clk  input  1  clock; all state updates on posedge clk.
REQ-004 rstn  input  1  reset, synchronous, active-low.
REQ-005 write_output  input  1  core request to emit one word this cycle.
REQ-006 write_data  input  32  word to emit; sampled when a write is accepted.
REQ-007 stall  output  1  core stall request; the write is not accepted this cycle.
REQ-008 tx_valid  output  1  byte offered to the UART transmitter.
REQ-009 tx_data  output  8  byte offered; held stable while tx_valid=1 and tx_ready=0.
REQ-010 tx_ready  input  1  transmitter accepts the byte this cycle when tx_valid=1.
REQ-011 out_empty  output  1  high when the FIFO is empty and no byte is in flight; used for end-of-run drain.

Function
REQ-012 SHALL compute stall = write_output & full, combinationally, where full = (count == DEPTH).
REQ-013 SHALL accept a write when write_output & ~full; the accepted word SHALL drive the bram write request combinationally (waddr=wptr, wdata=write_data, wenable=1) in the same cycle.
REQ-014 SHALL increment wptr modulo DEPTH on each accepted write, wrapping DEPTH-1 -> 0.
REQ-015 SHALL hold count (width clog2(DEPTH)+1): +1 on accept only, -1 on pop only, unchanged when both occur in the same cycle.
REQ-016 SHALL use FSM states IDLE, FETCH and SEND.
REQ-017 IDLE: when count != 0, SHALL present raddr=rptr and go to FETCH; otherwise SHALL stay in IDLE.
REQ-018 FETCH: SHALL wait one cycle for bram read latency, then load rdata into a 32-bit shift register, set byte_idx=0 and go to SEND.
REQ-019 SEND: SHALL drive tx_valid=1 and tx_data=shreg[7:0].
REQ-020 SEND: on tx_valid & tx_ready with byte_idx == NBYTES-1, SHALL pop (rptr++ modulo DEPTH, count-1) and go to IDLE.
REQ-021 SEND: on tx_valid & tx_ready with byte_idx < NBYTES-1, SHALL shift shreg right by 8 and increment byte_idx.
REQ-022 SHALL deassert tx_valid in every state other than SEND.
REQ-023 SHALL make a word written at posedge E readable from raddr presented in the following cycle; the write-then-read path SHALL return the new data.
REQ-024 SHALL keep an entry counted in count until its last byte is handshaken, so the FIFO cannot overwrite a word still being sent.
REQ-025 SHALL drive out_empty = (count == 0) & (state == IDLE).

Reset
REQ-026 On rstn=0 at posedge clk, SHALL set state=IDLE, wptr=0, rptr=0, count=0, byte_idx=0, shreg=0, tx_data=0, tx_valid=0; out_empty SHALL read 1.
REQ-027 Reset mid-SEND SHALL drop the in-flight byte and all buffered words; bram contents are don't-care.
REQ-028 stall SHALL read 0 during reset, since full=0.

Structure
REQ-029 SHALL use the bram_wreq_t typedef from package utils for the write request; no new package types.
REQ-030 SHALL instantiate exactly one sub-module, bram (MEMSIZE=DEPTH), as the FIFO storage.
REQ-031 SHALL keep the FSM enum local to the module.

Verification
REQ-032 NBYTES=1, tx_ready=1 constant; write 0x41, 0x42 back-to-back -> tx_data 0x41 then 0x42, one handshake each; out_empty returns to 1.
REQ-033 NBYTES=4; write 0x44332211 with tx_ready=1 -> bytes 0x11, 0x22, 0x33, 0x44 in order; count 1 -> 0 after the 4th handshake.
REQ-034 DEPTH=4, tx_ready=0; 5 consecutive writes -> stall=0 for the first 4 and stall=1 on the 5th; raising tx_ready then drains 4 words in order.
REQ-035 Full FIFO with write_output=1 while the final handshake of the head word occurs -> stall=1 that cycle and the write accepted next cycle; count never exceeds DEPTH.
REQ-036 DEPTH=4; stream 10 words through -> pointer wrap-around preserves order 0..9.
REQ-037 Assert rstn=0 mid-SEND with 3 words queued -> next cycle tx_valid=0, out_empty=1, and no further bytes are emitted.

Source files
------------

// File: rtl/utils_pkg.sv
// Shared memory-interface types used across the codebase.
// Holds the BRAM write-request record that producers drive into bram.
package utils;

  localparam int BRAM_AW = 16;

  typedef struct packed {
    logic               wenable;
    logic [BRAM_AW-1:0] waddr;
    logic [31:0]        wdata;
  } bram_wreq_t;

endpackage

// File: rtl/bram.sv
// Single-port-write, single-port-read 32-bit block RAM with a one-cycle registered read.
// A write to the address being read in the same cycle is forwarded, so the reader sees the new word.
module bram
  import utils::*;
#(
  parameter int MEMSIZE = 1024
) (
  input  logic               clk,
  input  bram_wreq_t         wreq,
  input  logic [BRAM_AW-1:0] raddr,
  output logic [31:0]        rdata
);

  localparam int AW = $clog2(MEMSIZE);

  logic [31:0] mem [MEMSIZE];
  logic        wr_in_range;
  logic        rd_in_range;
  logic        wr_hit;

  // Addresses beyond MEMSIZE are ignored on write and read back as zero.
  assign wr_in_range = (wreq.waddr >> AW) == '0;
  assign rd_in_range = (raddr >> AW) == '0;
  assign wr_hit      = wreq.wenable && wr_in_range && (wreq.waddr == raddr);

  always_ff @(posedge clk) begin
    if (wreq.wenable && wr_in_range) begin
      mem[wreq.waddr[AW-1:0]] <= wreq.wdata;
    end
    if (wr_hit) begin
      rdata <= wreq.wdata;
    end else if (rd_in_range) begin
      rdata <= mem[raddr[AW-1:0]];
    end else begin
      rdata <= '0;
    end
  end

endmodule

// File: rtl/output_controller.sv
// Word FIFO between the core and a byte-wide UART transmitter; each word is sent LSB byte first.
// Handshake: a byte transfers on a posedge where tx_valid and tx_ready are both 1; tx_data is stable while tx_valid=1 and tx_ready=0.
module output_controller
  import utils::*;
#(
  parameter int DEPTH  = 1024,
  parameter int NBYTES = 1
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        write_output,
  input  logic [31:0] write_data,
  output logic        stall,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic        out_empty,
  output logic [1:0]  dbg_state
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SEND  = 2'd2
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [AW-1:0]      wptr;
  logic [AW-1:0]      rptr;
  logic [CW-1:0]      count;
  logic [1:0]         byte_idx;
  logic [31:0]        shreg;
  logic [31:0]        rdata;
  logic               full;
  logic               accept;
  logic               last_byte;
  logic               pop;
  logic               shift;
  bram_wreq_t         wreq;
  logic [BRAM_AW-1:0] raddr;

  assign full      = (count == CW'(DEPTH));
  assign accept    = write_output & ~full;
  assign stall     = write_output & full;
  assign last_byte = (byte_idx == 2'(NBYTES - 1));
  assign pop       = (state == SEND) & tx_ready & last_byte;
  assign shift     = (state == SEND) & tx_ready & ~last_byte;

  assign tx_valid  = (state == SEND);
  assign tx_data   = shreg[7:0];
  assign out_empty = (count == '0) & (state == IDLE);
  assign dbg_state = state;

  always_comb begin
    wreq               = '0;
    wreq.wenable       = accept;
    wreq.waddr[AW-1:0] = wptr;
    wreq.wdata         = write_data;
    raddr              = '0;
    raddr[AW-1:0]      = rptr;
  end

  bram #(
    .MEMSIZE(DEPTH)
  ) u_bram (
    .clk  (clk),
    .wreq (wreq),
    .raddr(raddr),
    .rdata(rdata)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (count != '0) state_nxt = FETCH;
      FETCH:   state_nxt = SEND;
      SEND:    if (pop) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // The head word stays counted until its last byte leaves, so a full FIFO never overwrites it.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state    <= IDLE;
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      byte_idx <= '0;
      shreg    <= '0;
    end else begin
      state <= state_nxt;
      if (accept) wptr <= wptr + 1'b1;
      if (pop)    rptr <= rptr + 1'b1;
      case ({accept, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (state == FETCH) begin
        shreg    <= rdata;
        byte_idx <= '0;
      end else if (shift) begin
        shreg    <= shreg >> 8;
        byte_idx <= byte_idx + 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_output_controller.sv
// Directed bench for output_controller: one 4-deep byte-per-word instance and one 4-deep four-bytes-per-word instance.
// Emitted bytes are collected by negedge monitors and compared against hand-written expected queues.
module tb_output_controller;

  logic        clk = 1'b0;
  logic        rstn;

  logic        wr_a, stall_a, txv_a, txr_a, empty_a;
  logic [31:0] wd_a;
  logic [7:0]  txd_a;
  logic [1:0]  dbg_a;

  logic        wr_b, stall_b, txv_b, txr_b, empty_b;
  logic [31:0] wd_b;
  logic [7:0]  txd_b;
  logic [1:0]  dbg_b;

  logic [7:0]  got_a[$];
  logic [7:0]  got_b[$];
  logic [31:0] exp_q[$];

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  output_controller #(.DEPTH(4), .NBYTES(1)) u_dut_a (
    .clk         (clk),
    .rstn        (rstn),
    .write_output(wr_a),
    .write_data  (wd_a),
    .stall       (stall_a),
    .tx_valid    (txv_a),
    .tx_data     (txd_a),
    .tx_ready    (txr_a),
    .out_empty   (empty_a),
    .dbg_state   (dbg_a)
  );

  output_controller #(.DEPTH(4), .NBYTES(4)) u_dut_b (
    .clk         (clk),
    .rstn        (rstn),
    .write_output(wr_b),
    .write_data  (wd_b),
    .stall       (stall_b),
    .tx_valid    (txv_b),
    .tx_data     (txd_b),
    .tx_ready    (txr_b),
    .out_empty   (empty_b),
    .dbg_state   (dbg_b)
  );

  always @(negedge clk) begin
    if (rstn && txv_a && txr_a) got_a.push_back(txd_a);
    if (rstn && txv_b && txr_b) got_b.push_back(txd_b);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_a(input logic [31:0] d);
    int n;
    n    = 0;
    wr_a = 1'b1;
    wd_a = d;
    @(negedge clk);
    while (stall_a && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("write_a_timeout", 32'd1, 32'd0);
    @(posedge clk);
    #1;
    wr_a = 1'b0;
  endtask

  task automatic wait_empty(input string tag, input bit sel);
    int n;
    n = 0;
    @(negedge clk);
    while (!(sel ? empty_b : empty_a) && n < 300) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(sel ? empty_b : empty_a), 32'd1);
    tick();
  endtask

  task automatic compare_bytes(input string tag, input bit sel);
    logic [7:0] q[$];
    int         n;
    q = sel ? got_b : got_a;
    check({tag, "_count"}, 32'(q.size()), 32'(exp_q.size()));
    n = (q.size() < exp_q.size()) ? q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_byte%0d", tag, i), 32'(q[i]), exp_q[i]);
    end
    got_a.delete();
    got_b.delete();
    exp_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 1'b0;
    wr_a = 1'b1;
    wd_a = 32'h0;
    txr_a = 1'b0;
    wr_b = 1'b0;
    wd_b = 32'h0;
    txr_b = 1'b0;

    // Reset state, with a write request held high while in reset.
    repeat (2) tick();
    @(negedge clk);
    check("reset_stall", 32'(stall_a), 32'd0);
    check("reset_empty", 32'(empty_a), 32'd1);
    check("reset_valid", 32'(txv_a), 32'd0);
    check("reset_data", 32'(txd_a), 32'h0);
    check("reset_empty_b", 32'(empty_b), 32'd1);
    tick();
    wr_a = 1'b0;
    rstn = 1'b1;
    tick();

    // Two back-to-back single-byte words with the transmitter always ready.
    txr_a = 1'b1;
    write_a(32'h41);
    write_a(32'h42);
    exp_q.push_back(32'h41);
    exp_q.push_back(32'h42);
    wait_empty("req032_empty", 1'b0);
    compare_bytes("req032", 1'b0);

    // Four bytes per word, LSB first.
    txr_b = 1'b1;
    wr_b  = 1'b1;
    wd_b  = 32'h44332211;
    @(negedge clk);
    check("req033_stall", 32'(stall_b), 32'd0);
    tick();
    wr_b = 1'b0;
    @(negedge clk);
    check("req033_busy", 32'(empty_b), 32'd0);
    tick();
    foreach (exp_q[i]) exp_q.delete(i);
    exp_q.push_back(32'h11);
    exp_q.push_back(32'h22);
    exp_q.push_back(32'h33);
    exp_q.push_back(32'h44);
    wait_empty("req033_empty", 1'b1);
    compare_bytes("req033", 1'b1);

    // Fill to capacity with the transmitter blocked; the fifth write stalls.
    txr_a = 1'b0;
    for (int k = 0; k < 5; k++) begin
      wr_a = 1'b1;
      wd_a = 32'h10 + 32'(k);
      @(negedge clk);
      check($sformatf("req034_stall%0d", k), 32'(stall_a), (k == 4) ? 32'd1 : 32'd0);
      tick();
    end
    wr_a = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    check("req034_hold_valid", 32'(txv_a), 32'd1);
    check("req034_hold_data", 32'(txd_a), 32'h10);
    tick();
    txr_a = 1'b1;
    for (int k = 0; k < 4; k++) exp_q.push_back(32'h10 + 32'(k));
    wait_empty("req034_empty", 1'b0);
    compare_bytes("req034", 1'b0);

    // Full FIFO: the write coinciding with the head's final handshake stalls, then lands next cycle.
    txr_a = 1'b0;
    for (int k = 0; k < 4; k++) write_a(32'h20 + 32'(k));
    repeat (3) tick();
    wr_a  = 1'b1;
    wd_a  = 32'h30;
    txr_a = 1'b1;
    @(negedge clk);
    check("req035_stall_full", 32'(stall_a), 32'd1);
    check("req035_valid", 32'(txv_a), 32'd1);
    tick();
    @(negedge clk);
    check("req035_accept", 32'(stall_a), 32'd0);
    tick();
    wr_a = 1'b0;
    for (int k = 0; k < 4; k++) exp_q.push_back(32'h20 + 32'(k));
    exp_q.push_back(32'h30);
    wait_empty("req035_empty", 1'b0);
    compare_bytes("req035", 1'b0);

    // Ten words through a four-entry FIFO to exercise pointer wrap.
    txr_a = 1'b1;
    for (int k = 0; k < 10; k++) begin
      write_a(32'(k));
      exp_q.push_back(32'(k));
    end
    wait_empty("req036_empty", 1'b0);
    compare_bytes("req036", 1'b0);

    // Reset while a byte is being offered with three words queued.
    txr_a = 1'b0;
    for (int k = 0; k < 3; k++) write_a(32'h50 + 32'(k));
    repeat (3) tick();
    @(negedge clk);
    check("req037_sending", 32'(txv_a), 32'd1);
    tick();
    rstn = 1'b0;
    tick();
    @(negedge clk);
    check("req037_valid", 32'(txv_a), 32'd0);
    check("req037_empty", 32'(empty_a), 32'd1);
    tick();
    rstn  = 1'b1;
    txr_a = 1'b1;
    got_a.delete();
    repeat (10) tick();
    @(negedge clk);
    check("req037_no_bytes", 32'(got_a.size()), 32'd0);
    check("req037_still_empty", 32'(empty_a), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
